eth_tx_sched: RTL and testbench
===============================

// Module: eth_tx_sched
// PURPOSE
//  Shares the single RMII transmit path (eth_tx_ctrl + its payload FIFO) between pNUM_REQ
//  packet sources (e.g. ARP responder, UDP streamer). Round-robin arbitration; the grant is
//  held for one whole frame. Launches the frame, tracks it to completion, then enforces the
//  inter-packet gap before the next grant. Sits between the source FIFOs and eth_tx_ctrl.
// PARAMETERS
//  pNUM_REQ      4    number of requesters, 2..8
//  pIPG_CNT      48   idle clocks after Tx_En falls (96 bit times at 2 bits/clk)
//  pLAUNCH_TMO   64   max clocks from Eth_Pkt_Rdy until Tx_En must rise
// PORTS
//  Clk          in   1                    RMII reference clock, 50 MHz
//  Rst          in   1                    async active-high reset
//  Req          in   pNUM_REQ             level; source k has a complete frame in its FIFO
//  Gnt          out  pNUM_REQ             one-hot grant, held for the whole frame
//  Sel          out  $clog2(pNUM_REQ)     binary index of the granted source, drives the FIFO mux
//  Done         out  pNUM_REQ             one-clock pulse to the granted source at frame end
//  Err          out  1                    one-clock pulse on launch timeout
//  Eth_Pkt_Rdy  out  1                    one-clock pulse to eth_tx_ctrl to start a frame
//  Tx_En        in   1                    from eth_tx_ctrl; high while a frame is on the wire
//  Busy         out  1                    high in every state except SCHED_IDLE
// BEHAVIOUR
//  Reset: async assert -> all outputs 0, state SCHED_IDLE, counter 0, RR pointer 0.
//   Reset mid-frame drops Gnt immediately. No Done is issued for the aborted frame.
//  Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
//  FSM:
//   SCHED_IDLE:   if |Req -> latch RR winner into Gnt/Sel; go SCHED_LAUNCH.
//   SCHED_LAUNCH: Eth_Pkt_Rdy=1 for exactly the first clock in this state.
//                 Cnt increments each clock.
//                 Tx_En==1 -> SCHED_ACTIVE, Cnt=0.
//                 Cnt==pLAUNCH_TMO-1 with Tx_En==0 -> Err pulse, Gnt=0, Cnt=0, SCHED_IPG.
//                 No Done is issued on timeout.
//   SCHED_ACTIVE: wait for Tx_En==0 (falling edge) -> Done[Sel] pulse, Gnt=0, Cnt=0, SCHED_IPG.
//   SCHED_IPG:    Cnt increments; Cnt==pIPG_CNT-1 -> SCHED_IDLE.
//                 Tx_En rising here is a protocol error: ignored, no state change.
//  Latency: Req seen in SCHED_IDLE -> Gnt registered on the next edge.
//   Eth_Pkt_Rdy follows 1 clock after Gnt.
//   Back-to-back frames are separated by at least pIPG_CNT clocks of Tx_En low.
//  Arbitration: round robin. Search starts at RR pointer. After a grant, pointer = winner+1
//   (mod pNUM_REQ). Pointer advances on timeout too. Only requests sampled in SCHED_IDLE compete.
//  Requests: Req deassert while granted is ignored; the frame continues and Done still fires.
//   Gnt remains one-hot or zero at all times. Sel holds its last value when Gnt==0.
//  Simultaneous events: Tx_En fall and Req change on the same clock -> Done first,
//   new Req considered only after IPG.
//  Width: Cnt is $clog2(max(pIPG_CNT,pLAUNCH_TMO)) bits. Counters never wrap.
// STRUCTURE
//  eth_tx_pkg gains:
//   - eth_tx_sched_state_t {SCHED_IDLE, SCHED_LAUNCH, SCHED_ACTIVE, SCHED_IPG}
//   - pIPG_CNT
//   - pLAUNCH_TMO defaults
//  One sub-module, eth_rr_arb (combinational):
//   - inputs Req, pointer
//   - outputs one-hot winner + index
//   - FSM and counter stay in eth_tx_sched.
// TESTING
//  1 Single source: Req=4'b0001; model Tx_En high 200 clks -> Gnt=0001, one Eth_Pkt_Rdy,
//    Done[0] at Tx_En fall, Busy low 48 clks later.
//  2 All request: Req=4'b1111 held -> grant order 0,1,2,3,0.
//    Tx_En rise gap from previous fall >=48 clks each time.
//  3 Launch timeout: Req=4'b0010, Tx_En held 0 -> Err pulse 64 clks after Eth_Pkt_Rdy,
//    no Done, next grant goes to source 2 if requesting.
//  4 Req drop mid-frame: Req[1] falls during SCHED_ACTIVE -> Gnt held, Done[1] still pulses.
//  5 Async reset in SCHED_ACTIVE: Rst pulse between edges -> Gnt, Sel, Busy=0 immediately.
//    Next grant starts at source 0.
//  6 Spurious Tx_En in SCHED_IPG -> no state change, no Eth_Pkt_Rdy, no Done.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet transmit path.
// Holds the scheduler state encoding and its timing defaults.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_LAUNCH = 2'd1,
    SCHED_ACTIVE = 2'd2,
    SCHED_IPG    = 2'd3
  } eth_tx_sched_state_t;

  // 96 bit times of gap at 2 bits per RMII clock
  localparam int pIPG_CNT    = 48;
  localparam int pLAUNCH_TMO = 64;

  // One counter serves both the launch timeout and the gap, so size it for the larger
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// Request/grant and launch handshake between packet sources, the scheduler
// and eth_tx_ctrl. The scheduler side is the master modport.
interface eth_tx_sched_if #(
  parameter int pNUM_REQ = 4
);
  localparam int SEL_W = $clog2(pNUM_REQ);

  logic [pNUM_REQ-1:0] Req;
  logic [pNUM_REQ-1:0] Gnt;
  logic [SEL_W-1:0]    Sel;
  logic [pNUM_REQ-1:0] Done;
  logic                Err;
  logic                Eth_Pkt_Rdy;
  logic                Tx_En;
  logic                Busy;

  modport master (
    input  Req, Tx_En,
    output Gnt, Sel, Done, Err, Eth_Pkt_Rdy, Busy
  );

  modport slave (
    output Req, Tx_En,
    input  Gnt, Sel, Done, Err, Eth_Pkt_Rdy, Busy
  );
endinterface

// File: rtl/eth_rr_arb.sv
// Combinational round-robin picker: the first asserted request at or after
// Ptr (wrapping) wins; returned both one-hot and as a binary index.
module eth_rr_arb #(
  parameter  int pNUM_REQ = 4,
  localparam int SEL_W    = $clog2(pNUM_REQ)
) (
  input  logic [pNUM_REQ-1:0] Req,
  input  logic [SEL_W-1:0]    Ptr,
  output logic [pNUM_REQ-1:0] Win,
  output logic [SEL_W-1:0]    Win_Idx,
  output logic                Win_Vld
);

  logic [SEL_W-1:0]    cand_idx [pNUM_REQ];
  logic [pNUM_REQ-1:0] cand_hit;

  // Candidate gi is the requester gi places after the pointer
  genvar gi;
  generate
    for (gi = 0; gi < pNUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = SEL_W'((int'(Ptr) + gi) % pNUM_REQ);
      assign cand_hit[gi] = Req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    Win_Idx = '0;
    Win     = '0;
    Win_Vld = |Req;
    // Scan from the far end so the candidate closest to the pointer is kept last
    for (int i = pNUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        Win_Idx = cand_idx[i];
      end
    end
    if (Win_Vld) begin
      Win[Win_Idx] = 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Shares the single RMII transmit path between pNUM_REQ packet sources:
// round-robin grant per frame, launch, completion tracking, inter-packet gap.
module eth_tx_sched #(
  parameter int pNUM_REQ    = 4,
  parameter int pIPG_CNT    = eth_tx_pkg::pIPG_CNT,
  parameter int pLAUNCH_TMO = eth_tx_pkg::pLAUNCH_TMO
) (
  input  logic            Clk,
  input  logic            Rst,
  eth_tx_sched_if.master  bus
);
  import eth_tx_pkg::*;

  localparam int SEL_W = $clog2(pNUM_REQ);
  localparam int CNT_W = cnt_width(pIPG_CNT, pLAUNCH_TMO);

  eth_tx_sched_state_t state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [pNUM_REQ-1:0] gnt_reg, gnt_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    ptr_reg, ptr_next;
  logic [pNUM_REQ-1:0] done_reg, done_next;
  logic                err_reg, err_next;
  logic                pkt_rdy_reg, pkt_rdy_next;
  logic                launched_reg, launched_next;

  logic [pNUM_REQ-1:0] win_onehot;
  logic [SEL_W-1:0]    win_idx;
  logic                win_vld;

  eth_rr_arb #(
    .pNUM_REQ (pNUM_REQ)
  ) u_arb (
    .Req     (bus.Req),
    .Ptr     (ptr_reg),
    .Win     (win_onehot),
    .Win_Idx (win_idx),
    .Win_Vld (win_vld)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg    <= SCHED_IDLE;
      cnt_reg      <= '0;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      done_reg     <= '0;
      err_reg      <= 1'b0;
      pkt_rdy_reg  <= 1'b0;
      launched_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      ptr_reg      <= ptr_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      pkt_rdy_reg  <= pkt_rdy_next;
      launched_reg <= launched_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    ptr_next      = ptr_reg;
    done_next     = '0;
    err_next      = 1'b0;
    pkt_rdy_next  = 1'b0;
    launched_next = launched_reg;

    unique case (state_reg)
      SCHED_IDLE: begin
        if (win_vld) begin
          gnt_next      = win_onehot;
          sel_next      = win_idx;
          // Pointer moves at grant time, so a timed-out source also loses its turn
          ptr_next      = (win_idx == SEL_W'(pNUM_REQ - 1)) ? '0 : win_idx + SEL_W'(1);
          cnt_next      = '0;
          launched_next = 1'b0;
          state_next    = SCHED_LAUNCH;
        end
      end

      SCHED_LAUNCH: begin
        // Launch pulse lands one clock after Gnt; the timeout is measured from it
        if (!launched_reg) begin
          pkt_rdy_next  = 1'b1;
          launched_next = 1'b1;
        end else if (bus.Tx_En) begin
          cnt_next   = '0;
          state_next = SCHED_ACTIVE;
        end else if (cnt_reg == CNT_W'(pLAUNCH_TMO - 1)) begin
          err_next   = 1'b1;
          gnt_next   = '0;
          cnt_next   = '0;
          state_next = SCHED_IPG;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      SCHED_ACTIVE: begin
        if (!bus.Tx_En) begin
          done_next[sel_reg] = 1'b1;
          gnt_next           = '0;
          cnt_next           = '0;
          state_next         = SCHED_IPG;
        end
      end

      SCHED_IPG: begin
        // Tx_En is deliberately not looked at here
        if (cnt_reg == CNT_W'(pIPG_CNT - 1)) begin
          cnt_next   = '0;
          state_next = SCHED_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        gnt_next   = '0;
        cnt_next   = '0;
        state_next = SCHED_IDLE;
      end
    endcase
  end

  assign bus.Gnt         = gnt_reg;
  assign bus.Sel         = sel_reg;
  assign bus.Done        = done_reg;
  assign bus.Err         = err_reg;
  assign bus.Eth_Pkt_Rdy = pkt_rdy_reg;
  assign bus.Busy        = (state_reg != SCHED_IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched: directed frame table, randomized
// frames against a round-robin/timing reference, async reset and IPG corners.
module tb_eth_tx_sched;

  localparam int N   = 4;
  localparam int IPG = 48;
  localparam int TMO = 64;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  eth_tx_sched_if #(.pNUM_REQ(N)) ifc ();

  eth_tx_sched #(
    .pNUM_REQ    (N),
    .pIPG_CNT    (IPG),
    .pLAUNCH_TMO (TMO)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ifc)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int rdy_seen  = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int model_ptr = 0;

  typedef struct {
    logic [3:0] req;
    int         dly;      // clocks from Eth_Pkt_Rdy until Tx_En is seen high
    int         len;      // clocks Tx_En stays high
    bit         drop;     // drop Req mid-frame
    bit         spur;     // spurious Tx_En during the gap
    int         exp_idx;
    bit         exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge Clk);
    rdy_seen  += int'(ifc.Eth_Pkt_Rdy);
    done_seen += int'(ifc.Done != '0);
    err_seen  += int'(ifc.Err);
  endtask

  // Reference round-robin: first requester at or after ptr, wrapping
  function automatic int rr_pick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // Runs one frame from an idle scheduler and leaves it idle again
  task automatic run_frame(input logic [3:0] req, input int dly, input int len,
                           input bit drop, input bit spur,
                           input int exp_idx, input bit exp_err);
    logic [3:0] exp_oh;
    int r0, d0, e0;
    exp_oh = 4'(1 << exp_idx);
    r0 = rdy_seen; d0 = done_seen; e0 = err_seen;

    ifc.Req = req;
    step();
    chk("gnt", int'(ifc.Gnt), int'(exp_oh));
    chk("sel", int'(ifc.Sel), exp_idx);
    chk("rdy_before_gnt_plus1", int'(ifc.Eth_Pkt_Rdy), 0);
    step();
    chk("rdy", int'(ifc.Eth_Pkt_Rdy), 1);

    if (!exp_err) begin
      for (int k = 1; k < dly; k++) step();
      ifc.Tx_En = 1'b1;
      for (int k = 0; k < len; k++) begin
        step();
        if (drop && k == len / 2) ifc.Req = '0;
      end
      chk("gnt_hold", int'(ifc.Gnt), int'(exp_oh));
      ifc.Tx_En = 1'b0;
      step();
      chk("done", int'(ifc.Done), int'(exp_oh));
      chk("gnt_drop", int'(ifc.Gnt), 0);
    end else begin
      for (int k = 0; k < TMO - 1; k++) step();
      chk("err_early", int'(ifc.Err), 0);
      chk("gnt_launch", int'(ifc.Gnt), int'(exp_oh));
      step();
      chk("err", int'(ifc.Err), 1);
      chk("gnt_tmo", int'(ifc.Gnt), 0);
      chk("done_tmo", int'(ifc.Done), 0);
    end

    ifc.Req = '0;
    for (int k = 1; k < IPG; k++) begin
      step();
      if (spur && k == 5) ifc.Tx_En = 1'b1;
      if (spur && k == 9) ifc.Tx_En = 1'b0;
    end
    chk("busy_ipg", int'(ifc.Busy), 1);
    step();
    chk("idle_after_ipg", int'(ifc.Busy), 0);
    chk("sel_hold", int'(ifc.Sel), exp_idx);
    chk("rdy_count", rdy_seen - r0, 1);
    chk("done_count", done_seen - d0, exp_err ? 0 : 1);
    chk("err_count", err_seen - e0, int'(exp_err));
    model_ptr = (exp_idx + 1) % N;
  endtask

  initial begin
    logic [3:0] req;
    int dly, idx, d0;

    tbl[0]  = '{4'b0001,  3, 200, 1'b0, 1'b0, 0, 1'b0};
    tbl[1]  = '{4'b1111,  1,  10, 1'b0, 1'b0, 1, 1'b0};
    tbl[2]  = '{4'b1111,  5,   5, 1'b0, 1'b0, 2, 1'b0};
    tbl[3]  = '{4'b1111, 64,   3, 1'b0, 1'b0, 3, 1'b0};
    tbl[4]  = '{4'b1111,  2,   4, 1'b0, 1'b0, 0, 1'b0};
    tbl[5]  = '{4'b0010, 65,   0, 1'b0, 1'b0, 1, 1'b1};
    tbl[6]  = '{4'b0110,  2,   6, 1'b0, 1'b0, 2, 1'b0};
    tbl[7]  = '{4'b0010,  4,  20, 1'b1, 1'b0, 1, 1'b0};
    tbl[8]  = '{4'b1011,  2,   5, 1'b0, 1'b1, 3, 1'b0};
    tbl[9]  = '{4'b0110,  1,   1, 1'b0, 1'b0, 1, 1'b0};
    tbl[10] = '{4'b1001,  7,   8, 1'b0, 1'b0, 3, 1'b0};

    ifc.Req   = '0;
    ifc.Tx_En = 1'b0;
    repeat (3) step();
    chk("rst_gnt",  int'(ifc.Gnt), 0);
    chk("rst_sel",  int'(ifc.Sel), 0);
    chk("rst_busy", int'(ifc.Busy), 0);
    chk("rst_done", int'(ifc.Done), 0);
    chk("rst_err",  int'(ifc.Err), 0);
    chk("rst_rdy",  int'(ifc.Eth_Pkt_Rdy), 0);
    Rst = 1'b0;
    step();
    chk("idle_no_req", int'(ifc.Busy), 0);

    for (int i = 0; i < 11; i++) begin
      $display("vec %0d: req=%b dly=%0d len=%0d exp_idx=%0d exp_err=%0d",
               i, tbl[i].req, tbl[i].dly, tbl[i].len, tbl[i].exp_idx, tbl[i].exp_err);
      run_frame(tbl[i].req, tbl[i].dly, tbl[i].len, tbl[i].drop, tbl[i].spur,
                tbl[i].exp_idx, tbl[i].exp_err);
    end

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("idle_gap", int'(ifc.Busy), 0);
      end
      req = 4'($urandom_range(1, 15));
      dly = ($urandom_range(0, 9) == 0) ? 65 + $urandom_range(0, 10) : $urandom_range(1, 20);
      idx = rr_pick(req, model_ptr);
      $display("rnd %0d: req=%b dly=%0d exp_idx=%0d", i, req, dly, idx);
      run_frame(req, dly, $urandom_range(1, 40), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), idx, dly > TMO);
    end

    // Async reset in the middle of an active frame
    ifc.Req = 4'b1111;
    idx = rr_pick(4'b1111, model_ptr);
    step();
    chk("mid_gnt", int'(ifc.Gnt), 1 << idx);
    step();
    ifc.Tx_En = 1'b1;
    repeat (5) step();
    d0 = done_seen;
    #2 Rst = 1'b1;
    #1;
    chk("arst_gnt",  int'(ifc.Gnt), 0);
    chk("arst_sel",  int'(ifc.Sel), 0);
    chk("arst_busy", int'(ifc.Busy), 0);
    ifc.Tx_En = 1'b0;
    ifc.Req   = '0;
    step();
    Rst = 1'b0;
    repeat (3) step();
    chk("arst_no_done", done_seen - d0, 0);
    $display("arst: next grant expected at source 0");
    model_ptr = 0;
    run_frame(4'b1111, 3, 4, 1'b0, 1'b0, rr_pick(4'b1111, model_ptr), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
